// File: rtl/polar_enc_sched_pkg.sv
// Shared definitions for the polar encoder scheduler: code dimensions, FSM states
// and the information-position mask used by polar_encoder.
`ifndef N
`define N 8
`endif
`ifndef F
`define F 4
`endif
`ifndef MESSAGE_LENGTH
`define MESSAGE_LENGTH 8
`endif

package polar_enc_sched_pkg;

  localparam int POLAR_N       = `N;
  localparam int POLAR_F       = `F;
  localparam int POLAR_K       = POLAR_N - POLAR_F;
  localparam int POLAR_LOG_N   = $clog2(POLAR_N);
  localparam int POLAR_MSG_LEN = `MESSAGE_LENGTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    OUT  = 2'd2
  } sched_state_t;

  // Information set = the K generator rows of highest Hamming weight, ties broken
  // towards the higher index; for N=8, F=4 this freezes u0, u1, u2 and u4.
  function automatic logic [POLAR_N-1:0] info_mask();
    logic [POLAR_N-1:0] mask;
    int picked;
    int wt;
    mask   = '0;
    picked = 0;
    for (int w = POLAR_LOG_N; w >= 0; w--) begin
      for (int i = POLAR_N - 1; i >= 0; i--) begin
        wt = 0;
        for (int b = 0; b < POLAR_LOG_N; b++) wt += (i >> b) & 1;
        if (wt == w && picked < POLAR_K) begin
          mask[i] = 1'b1;
          picked++;
        end
      end
    end
    return mask;
  endfunction

  localparam logic [POLAR_N-1:0] INFO_MASK = info_mask();

endpackage

// File: rtl/polar_encoder.sv
// Combinational polar encoder: the top K message bits fill the information
// positions in ascending order, frozen positions are forced to 0, then x = u * G_N.
module polar_encoder
  import polar_enc_sched_pkg::*;
(
  input  logic [POLAR_MSG_LEN-1:0] msg,
  output logic [POLAR_N-1:0]       code
);

  logic [POLAR_N-1:0] u;
  logic [POLAR_N-1:0] x;

  always_comb begin
    int k;
    u = '0;
    k = 0;
    for (int j = 0; j < POLAR_N; j++) begin
      if (INFO_MASK[j]) begin
        u[j] = msg[POLAR_MSG_LEN - POLAR_K + k];
        k++;
      end
    end
  end

  // In-place butterfly: each stage folds the upper half of every pair into the lower.
  always_comb begin
    x = u;
    for (int s = 0; s < POLAR_LOG_N; s++) begin
      for (int j = 0; j < POLAR_N; j++) begin
        if (((j >> s) & 1) == 0) x[j] = x[j] ^ x[j + (1 << s)];
      end
    end
  end

  assign code = x;

endmodule

// File: rtl/polar_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// when scanning from rr_ptr upwards, modulo NUM_REQ.
module polar_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    // Scan farthest-first so the nearest requester is the last (winning) write.
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/polar_enc_sched.sv
// Round-robin front end for polar_encoder: accept one message, encode, present tagged codeword.
// Optional per-requester grant counters are enabled with macro POLAR_SCHED_STATS_EN.
module polar_enc_sched
  import polar_enc_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MSG_LEN = `MESSAGE_LENGTH,
  parameter int CW_LEN  = `N,
  parameter int SRC_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*MSG_LEN-1:0] req_msg_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [CW_LEN-1:0]          out_code_o,
  output logic [SRC_W-1:0]           out_src_o,
  output logic                       busy_o
`ifdef POLAR_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]      grant_cnt_o
`endif
);

  genvar gi;

  sched_state_t        state_reg, state_next;
  logic [SRC_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [MSG_LEN-1:0]  msg_reg, msg_next;
  logic [SRC_W-1:0]    src_reg, src_next;
  logic [CW_LEN-1:0]   code_reg, code_next;
  logic [SRC_W-1:0]    out_src_reg, out_src_next;
  logic                out_valid_reg, out_valid_next;

  logic [NUM_REQ-1:0]  grant;
  logic [SRC_W-1:0]    grant_idx;
  logic [MSG_LEN-1:0]  granted_msg;
  logic [MSG_LEN-1:0]  masked_msg [NUM_REQ];
  logic [CW_LEN-1:0]   enc_code;

  polar_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (SRC_W)
  ) u_arb (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  polar_encoder u_enc (
    .msg  (msg_reg),
    .code (enc_code)
  );

  // AND-OR select keeps non-granted (possibly undriven) slices out of msg_reg.
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_msg_mask
    assign masked_msg[gi] = req_msg_i[gi*MSG_LEN +: MSG_LEN] & {MSG_LEN{grant[gi]}};
  end

  always_comb begin
    granted_msg = '0;
    for (int r = 0; r < NUM_REQ; r++) granted_msg = granted_msg | masked_msg[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      msg_reg       <= '0;
      src_reg       <= '0;
      code_reg      <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      msg_reg       <= msg_next;
      src_reg       <= src_next;
      code_reg      <= code_next;
      out_src_reg   <= out_src_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    msg_next       = msg_reg;
    src_next       = src_reg;
    code_next      = code_reg;
    out_src_next   = out_src_reg;
    out_valid_next = out_valid_reg;
    req_ready_o    = '0;
    case (state_reg)
      IDLE: begin
        req_ready_o = grant;
        if (|grant) begin
          msg_next    = granted_msg;
          src_next    = grant_idx;
          rr_ptr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
          state_next  = ENC;
        end
      end
      ENC: begin
        code_next      = enc_code;
        out_src_next   = src_reg;
        out_valid_next = 1'b1;
        state_next     = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_valid_o = out_valid_reg;
  assign out_code_o  = code_reg;
  assign out_src_o   = out_src_reg;
  assign busy_o      = (state_reg != IDLE);

`ifdef POLAR_SCHED_STATS_EN
  for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (state_reg == IDLE && grant[gi] && cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign grant_cnt_o[gi*16 +: 16] = cnt_reg;
  end
`endif

endmodule
